// File: rtl/input_conditioner.sv
// Switch and pushbutton front end: per-input synchronizer and debounce,
// plus a button FSM producing single-cycle PRESS and LONG-PRESS events.
module input_conditioner #(
    parameter int SW_WIDTH        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [SW_WIDTH-1:0] SW_RAW,
    input  logic                nBTN_RAW,
    output logic [SW_WIDTH-1:0] SW_STABLE,
    output logic                SW_CHANGED,
    output logic                BTN_LEVEL,
    output logic                BTN_PRESS,
    output logic                BTN_LONG
);

    localparam int CH     = SW_WIDTH + 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DOWN,
        S_LONG
    } btn_state_t;

    logic [SW_WIDTH-1:0]    sw_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] btn_sync;
    logic [CH-1:0]          synced;
    logic [CH-1:0]          stable;
    logic [CH-1:0]          differ;
    logic [CH-1:0]          expire;
    logic [DB_W-1:0]        db_cnt [CH];

    btn_state_t             state;
    btn_state_t             next_state;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [HOLD_W-1:0]      next_hold;
    logic                   hold_last;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_sync[s] <= '0;
            end
            btn_sync <= '1;
        end else begin
            sw_sync[0] <= SW_RAW;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_sync[s] <= sw_sync[s-1];
            end
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], nBTN_RAW};
        end
    end

    // The button channel is inverted here so every debounce channel rests at 0.
    assign synced = {~btn_sync[SYNC_STAGES-1], sw_sync[SYNC_STAGES-1]};

    always_comb begin
        differ = synced ^ stable;
        expire = '0;
        for (int c = 0; c < CH; c++) begin
            expire[c] = differ[c] && (db_cnt[c] == DB_LAST);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int c = 0; c < CH; c++) begin
                db_cnt[c] <= '0;
            end
            stable     <= '0;
            SW_CHANGED <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (!differ[c] || expire[c]) begin
                    db_cnt[c] <= '0;
                end else begin
                    db_cnt[c] <= db_cnt[c] + DB_ONE;
                end
            end
            stable     <= (stable & ~expire) | (synced & expire);
            SW_CHANGED <= |expire[SW_WIDTH-1:0];
        end
    end

    assign SW_STABLE = stable[SW_WIDTH-1:0];
    assign BTN_LEVEL = stable[SW_WIDTH];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= next_hold;
        end
    end

    assign hold_last = (hold_cnt == HOLD_LAST);

    // A release in the cycle the hold count completes wins over the long press.
    always_comb begin
        next_state = state;
        next_hold  = hold_cnt;
        case (state)
            S_IDLE: begin
                next_hold = '0;
                if (BTN_LEVEL) begin
                    next_state = S_DOWN;
                end
            end
            S_DOWN: begin
                if (!BTN_LEVEL) begin
                    next_state = S_IDLE;
                    next_hold  = '0;
                end else begin
                    next_hold = hold_cnt + HOLD_ONE;
                    if (hold_last) begin
                        next_state = S_LONG;
                    end
                end
            end
            S_LONG: begin
                if (!BTN_LEVEL) begin
                    next_state = S_IDLE;
                    next_hold  = '0;
                end
            end
            default: begin
                next_state = S_IDLE;
                next_hold  = '0;
            end
        endcase
    end

    always_comb begin
        BTN_PRESS = 1'b0;
        BTN_LONG  = 1'b0;
        case (state)
            S_IDLE:  BTN_PRESS = BTN_LEVEL;
            S_DOWN:  BTN_LONG  = BTN_LEVEL && hold_last;
            default: begin
                BTN_PRESS = 1'b0;
                BTN_LONG  = 1'b0;
            end
        endcase
    end

endmodule
